// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART debug dumper.
// Optional feature macro: UART_DUMP_CHECKSUM_EN (adds the CSUM state).
package uart_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
`ifdef UART_DUMP_CHECKSUM_EN
    ,
    ST_CSUM = 2'd3
`endif
  } state_e;

  localparam logic [7:0] CMD_DUMP_DEF = 8'h73;
  localparam logic [7:0] CMD_STEP_DEF = 8'h6E;
  localparam logic [7:0] HEADER_DEF   = 8'hA5;

  function automatic int bytes_per_word(input int word_w);
    return word_w / 8;
  endfunction

  // Index registers never shrink below one bit, even for a single word/byte.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_dbg_byte_sel.sv
// Combinational byte mux over the snapshot bank: word 0 first, MSB byte first.
// Unaffected by UART_DUMP_CHECKSUM_EN.
module uart_dbg_byte_sel #(
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 32,
  parameter int BPW       = 4,
  parameter int WIDX_W    = 3,
  parameter int BIDX_W    = 2
) (
  input  logic [NUM_WORDS*WORD_W-1:0] snap,
  input  logic [WIDX_W-1:0]           word_idx,
  input  logic [BIDX_W-1:0]           byte_idx,
  output logic [7:0]                  byte_out
);

  always_comb begin
    byte_out = 8'h00;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = 0; b < BPW; b++) begin
        // byte index 0 is the most significant byte of the word
        if (word_idx == WIDX_W'(w) && byte_idx == BIDX_W'(b)) begin
          byte_out = snap[w*WORD_W + (BPW-1-b)*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/uart_debug_dumper.sv
// Command-driven snapshot dumper feeding the UART TX FIFO, plus single-step pulse.
// Define UART_DUMP_CHECKSUM_EN to append an XOR checksum byte to each frame.
module uart_debug_dumper
  import uart_dbg_pkg::*;
#(
  parameter int         NUM_WORDS = 8,
  parameter int         WORD_W    = 32,
  parameter logic [7:0] CMD_DUMP  = CMD_DUMP_DEF,
  parameter logic [7:0] CMD_STEP  = CMD_STEP_DEF,
  parameter logic [7:0] HEADER    = HEADER_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_data_rdy,
  input  logic [NUM_WORDS*WORD_W-1:0] snap_data,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [7:0]                  fifo_din,
  output logic                        busy,
  output logic                        step_pulse,
  output logic                        cmd_err
);

  localparam int BPW    = bytes_per_word(WORD_W);
  localparam int WIDX_W = idx_width(NUM_WORDS);
  localparam int BIDX_W = idx_width(BPW);

  state_e                      state_q, state_d;
  logic [NUM_WORDS*WORD_W-1:0] snap_q, snap_d;
  logic [WIDX_W-1:0]           widx_q, widx_d;
  logic [BIDX_W-1:0]           bidx_q, bidx_d;
  logic                        step_q, step_d;
  logic                        err_q, err_d;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]                  csum_q, csum_d;
`endif

  logic       push;
  logic [7:0] push_byte;
  logic [7:0] sel_byte;
  logic       last_byte, last_word;

  uart_dbg_byte_sel #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W),
    .BPW       (BPW),
    .WIDX_W    (WIDX_W),
    .BIDX_W    (BIDX_W)
  ) u_byte_sel (
    .snap     (snap_q),
    .word_idx (widx_q),
    .byte_idx (bidx_q),
    .byte_out (sel_byte)
  );

  assign last_byte = (bidx_q == BIDX_W'(BPW - 1));
  assign last_word = (widx_q == WIDX_W'(NUM_WORDS - 1));

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    push      = 1'b0;
    push_byte = 8'h00;
`ifdef UART_DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_data_rdy) begin
          if (rx_data == CMD_DUMP) begin
            snap_d  = snap_data;
            widx_d  = '0;
            bidx_d  = '0;
`ifdef UART_DUMP_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
            state_d = ST_HDR;
          end else if (rx_data == CMD_STEP) begin
            step_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HDR: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_byte = HEADER;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_byte = sel_byte;
`ifdef UART_DUMP_CHECKSUM_EN
          csum_d    = csum_q ^ sel_byte;
`endif
          if (last_byte) begin
            bidx_d = '0;
            if (last_word) begin
`ifdef UART_DUMP_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_IDLE;
`endif
            end else begin
              widx_d = widx_q + 1'b1;
            end
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end

`ifdef UART_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_byte = csum_q;
          state_d   = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Commands are only decoded in IDLE; anything arriving mid-frame is dropped.
    if (rx_data_rdy && state_q != ST_IDLE) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      step_q  <= step_d;
      err_q   <= err_d;
`ifdef UART_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Gate the push during reset so an abandoned frame emits nothing more.
  assign fifo_wr_en = push & ~rst;
  assign fifo_din   = (push & ~rst) ? push_byte : 8'h00;
  assign busy       = (state_q != ST_IDLE);
  assign step_pulse = step_q;
  assign cmd_err    = err_q;

endmodule
